// File: rtl/fifo_param_if.sv
// Handshake and status bundle for fifo_param. The slave side is the FIFO and the master side is the producer/consumer.
interface fifo_param_if #(
  parameter int DATA_SIZE = 8,
  parameter int MAIN_SIZE = 4
);
  logic                 push;
  logic                 pop;
  logic [DATA_SIZE-1:0] data_in;
  logic [MAIN_SIZE:0]   afull_thr;
  logic [MAIN_SIZE:0]   aempty_thr;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic [MAIN_SIZE:0]   count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow_err;
  logic                 underflow_err;

  modport slave (
    input  push, pop, data_in, afull_thr, aempty_thr,
    output data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow_err, underflow_err
  );

  modport master (
    output push, pop, data_in, afull_thr, aempty_thr,
    input  data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO (depth 2^MAIN_SIZE) with occupancy count, programmable
// almost-full/almost-empty thresholds, a registered read port and sticky overflow/underflow flags.
module fifo_param #(
  parameter int DATA_SIZE = 8,
  parameter int MAIN_SIZE = 4
) (
  input  logic          clk,
  input  logic          reset,
  fifo_param_if.slave   fifo
);
  localparam int unsigned DEPTH = 2 ** MAIN_SIZE;
  localparam logic [MAIN_SIZE:0] LP_DEPTH = {1'b1, {MAIN_SIZE{1'b0}}};

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [MAIN_SIZE-1:0] r_wr_ptr;
  logic [MAIN_SIZE-1:0] r_rd_ptr;
  logic [MAIN_SIZE:0]   r_count;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_valid_out;
  logic                 r_overflow_err;
  logic                 r_underflow_err;

  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;

  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  // A push on full is only admitted when a pop frees a slot in the same cycle.
  assign w_pop_acc  = fifo.pop & ~w_empty;
  assign w_push_acc = fifo.push & (~w_full | w_pop_acc);

  // Storage is deliberately not reset; only writes in non-reset cycles land.
  always_ff @(posedge clk) begin
    if (reset && w_push_acc) begin
      r_mem[r_wr_ptr] <= fifo.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_data_out      <= '0;
      r_valid_out     <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_valid_out <= w_pop_acc;
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (fifo.push && !w_push_acc) begin
        r_overflow_err <= 1'b1;
      end
      if (fifo.pop && w_empty) begin
        r_underflow_err <= 1'b1;
      end
    end
  end

  assign fifo.data_out      = r_data_out;
  assign fifo.valid_out     = r_valid_out;
  assign fifo.count         = r_count;
  assign fifo.full          = w_full;
  assign fifo.empty         = w_empty;
  assign fifo.almost_full   = (r_count >= fifo.afull_thr);
  assign fifo.almost_empty  = (r_count <= fifo.aempty_thr);
  assign fifo.overflow_err  = r_overflow_err;
  assign fifo.underflow_err = r_underflow_err;
endmodule

// File: tb/tb_fifo_param.sv
// Directed vector bench for fifo_param (DATA_SIZE=8, MAIN_SIZE=4): a table of per-cycle
// stimulus with hand-derived expectations, followed by threshold corner sequences.
module tb_fifo_param;
  logic clk;
  logic reset;

  fifo_param_if #(.DATA_SIZE(8), .MAIN_SIZE(4)) bus ();

  fifo_param #(.DATA_SIZE(8), .MAIN_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       push;
    logic       pop;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       vld;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(input logic rst_n, input logic push, input logic pop,
                              input int din, input int cnt, input int dout,
                              input logic vld, input logic ovf, input logic udf);
    vec_t v;
    v.rst_n = rst_n;
    v.push  = push;
    v.pop   = pop;
    v.din   = din[7:0];
    v.cnt   = cnt;
    v.dout  = dout[7:0];
    v.vld   = vld;
    v.ovf   = ovf;
    v.udf   = udf;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic rst_n, input logic push, input logic pop, input logic [7:0] din);
    @(negedge clk);
    reset        = rst_n;
    bus.push     = push;
    bus.pop      = pop;
    bus.data_in  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.data_in    = '0;
    bus.afull_thr  = 5'd12;
    bus.aempty_thr = 5'd3;

    // reset for two cycles
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) add(1, 1, 0, i, i + 1, 0, 0, 0, 0);
    // push on full is dropped
    add(1, 1, 0, 'hAA, 16, 0, 0, 1, 0);
    // push+pop at full: count holds, 0x55 becomes the last word
    add(1, 1, 1, 'h55, 16, 'h00, 1, 1, 0);
    for (int i = 1; i < 16; i++) add(1, 0, 1, 0, 16 - i, i, 1, 1, 0);
    add(1, 0, 1, 0, 0, 'h55, 1, 1, 0);
    // pop on empty: data holds, no valid
    add(1, 0, 1, 0, 0, 'h55, 0, 1, 1);
    // push+pop on empty: no bypass
    add(1, 1, 1, 'h33, 1, 'h55, 0, 1, 1);
    add(1, 0, 1, 0, 0, 'h33, 1, 1, 1);
    // reset clears sticky errors
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 1, 0, 'h70 + i, i + 1, 0, 0, 0, 0);
    // reset with count 7; push/pop in that cycle are ignored
    add(0, 1, 1, 'hEE, 0, 0, 0, 0, 0);
    add(1, 1, 0, 'h99, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 'h99, 1, 0, 0);
    // 40 interleaved words, pointers wrap twice
    add(1, 1, 0, 'h40, 1, 'h99, 0, 0, 0);
    for (int i = 1; i < 40; i++) add(1, 1, 1, 'h40 + i, 1, 'h40 + i - 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 'h40 + 39, 1, 0, 0);

    foreach (vq[k]) begin
      drive(vq[k].rst_n, vq[k].push, vq[k].pop, vq[k].din);
      chk("count", k, 32'(bus.count), 32'(vq[k].cnt));
      chk("data_out", k, 32'(bus.data_out), 32'(vq[k].dout));
      chk("valid_out", k, 32'(bus.valid_out), 32'(vq[k].vld));
      chk("full", k, 32'(bus.full), 32'(vq[k].cnt == 16));
      chk("empty", k, 32'(bus.empty), 32'(vq[k].cnt == 0));
      chk("almost_full", k, 32'(bus.almost_full), 32'(vq[k].cnt >= 12));
      chk("almost_empty", k, 32'(bus.almost_empty), 32'(vq[k].cnt <= 3));
      chk("overflow_err", k, 32'(bus.overflow_err), 32'(vq[k].ovf));
      chk("underflow_err", k, 32'(bus.underflow_err), 32'(vq[k].udf));
    end

    // threshold corners at count 0
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.afull_thr = 5'd0;
    #1;
    chk("afull_thr0", 1000, 32'(bus.almost_full), 32'd1);
    bus.afull_thr = 5'd1;
    #1;
    chk("afull_thr1", 1001, 32'(bus.almost_full), 32'd0);

    // threshold corners at count 16
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("fill_count", 1002, 32'(bus.count), 32'd16);
    bus.aempty_thr = 5'd16;
    #1;
    chk("aempty_thr16", 1003, 32'(bus.almost_empty), 32'd1);
    bus.aempty_thr = 5'd15;
    #1;
    chk("aempty_thr15", 1004, 32'(bus.almost_empty), 32'd0);
    bus.afull_thr = 5'd16;
    #1;
    chk("afull_thr16", 1005, 32'(bus.almost_full), 32'd1);
    bus.afull_thr = 5'd17;
    #1;
    chk("afull_thr17", 1006, 32'(bus.almost_full), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("first_after_fill", 1007, 32'(bus.data_out), 32'hC0);
    chk("count_after_pop", 1008, 32'(bus.count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: the successor to the fixed 6x8 memory. It wraps a 2^MAIN_SIZE x DATA_SIZE storage array with internal write/read pointers, an occupancy counter, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits per virtual channel in the PCIe switching datapath, between the classifier and the arbiter. Upstream logic drives only push/pop instead of raw pointers.

## Interface
Parameters:
- DATA_SIZE, 8, word width in bits
- MAIN_SIZE, 4, address width; depth = 2^MAIN_SIZE (16 by default)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- push  input  1  write request; data_in captured if accepted
- pop  input  1  read request
- data_in  input  DATA_SIZE  write data
- afull_thr  input  MAIN_SIZE+1  almost-full threshold (static during operation)
- aempty_thr  input  MAIN_SIZE+1  almost-empty threshold (static during operation)
- data_out  output  DATA_SIZE  registered read data
- valid_out  output  1  data_out holds a word popped in the previous cycle
- count  output  MAIN_SIZE+1  current occupancy, 0..2^MAIN_SIZE
- full  output  1  count == 2^MAIN_SIZE
- empty  output  1  count == 0
- almost_full  output  1  count >= afull_thr
- almost_empty  output  1  count <= aempty_thr
- overflow_err  output  1  sticky: a push was rejected
- underflow_err  output  1  sticky: a pop was rejected

## Operation
- Internal state:
  - wr_ptr and rd_ptr, MAIN_SIZE bits each; natural wrap from 2^MAIN_SIZE-1 to 0.
  - count register, MAIN_SIZE+1 bits.
- Acceptance, evaluated on the pre-edge state:
  - pop_acc = pop & !empty.
  - push_acc = push & (!full | pop_acc).
  - Push on full is accepted only if a pop is accepted in the same cycle.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr += 1.
- Accepted pop: data_out <= mem[rd_ptr]; rd_ptr += 1.
- Count update:
  - +1 for push_acc only.
  - −1 for pop_acc only.
  - Unchanged when both or neither are accepted.
- No bypass: push and pop on an empty FIFO writes the word, flags underflow, and count becomes 1.
- Rejected push (push & !push_acc): data dropped; overflow_err <= 1 until reset.
- Rejected pop (pop & empty): data_out holds; valid_out <= 0; underflow_err <= 1 until reset.
- Status outputs: full, empty, almost_full and almost_empty are combinational from the count register only, never from push/pop.
- Thresholds:
  - afull_thr = 0 forces almost_full to 1.
  - aempty_thr >= 2^MAIN_SIZE forces almost_empty to 1.
- Reset (reset == 0 at a rising edge):
  - Pointers, count, data_out, valid_out, overflow_err and underflow_err all go to 0.
  - Memory array is not cleared.
  - Reset mid-operation discards all stored words; push/pop are ignored in the reset cycle.

## Timing
- Reset values: data_out = 0, valid_out = 0, count = 0, empty = 1, full = 0, almost_empty = 1 (for aempty_thr >= 0), almost_full = (afull_thr == 0), overflow_err = 0, underflow_err = 0.
- Write latency: a word pushed at edge N is poppable at edge N+1. empty deasserts after edge N.
- Read latency: one cycle.
  - pop_acc at edge N puts data_out and valid_out = 1 after edge N.
  - valid_out is a one-cycle pulse per accepted pop. Back-to-back pops give one word per cycle.
- Flags and count change only after a clock edge. There is no combinational path from push/pop to any output.
- Throughput: one push and one pop per cycle, sustained, including at full (simultaneous push+pop).

## Test plan
- Reset and fill:
  - Stimulus: reset low 2 cycles, then 16 pushes of 0x00..0x0F (MAIN_SIZE = 4).
  - Required: count steps 0→16; full = 1 after the 16th edge; empty = 0 after the first.
- Drain order:
  - Stimulus: 16 pops following the fill.
  - Required: data_out = 0x00..0x0F, each one cycle after its pop with valid_out = 1; empty = 1 after the last pop; no error flags.
- Overflow and underflow:
  - Stimulus: push 0xAA while full.
  - Required: overflow_err = 1, count stays 16, 0xAA never appears on data_out.
  - Stimulus: after draining, pop while empty.
  - Required: underflow_err = 1, data_out holds its last value, valid_out = 0.
- Simultaneous push/pop:
  - Stimulus: at full, push 0x55 + pop.
  - Required: count stays 16; 0x55 is read as the 16th word later.
  - Stimulus: at empty, push 0x33 + pop.
  - Required: count = 1, underflow_err = 1, next pop returns 0x33.
- Thresholds and wrap-around:
  - Setup: afull_thr = 12, aempty_thr = 3.
  - Required: almost_full rises after the 12th push; almost_empty falls after the 4th push.
  - Stimulus: 40 push/pop interleaved words.
  - Required: correct order across pointer wrap.
- Reset mid-operation:
  - Stimulus: with count = 7, assert reset for 1 cycle.
  - Required: count = 0, empty = 1, errors cleared; next push/pop round-trips 0x99.
